// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin owner of the 3-bit-select 1-of-8 decoder.
// Grants one of N_REQ requesters, holds until done or withdrawal, then
// inserts one GAP cycle and rotates priority past the released owner.
// Optional feature macro: RR_SEL_ARBITER_TIMEOUT_EN (force-release after
// MAX_HOLD BUSY cycles with a one-cycle timeout pulse).
module rr_sel_arbiter #(
    parameter int N_REQ    = 6,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             gnt_vld,
    output logic [2:0]       gnt_sel,
    output logic [7:0]       gnt,
    output logic             timeout
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_ptr;
    logic [2:0] r_sel;
    logic       r_gnt_vld;
    logic [7:0] r_gnt;
    logic       r_timeout;

    logic [7:0] w_req8;
    logic [2:0] w_pick;
    logic       w_any;
    int         w_idx;
    logic       w_rel_norm;
    logic       w_force;
    logic       w_leave;

    // Zero-extend so the owner lookup and scan never index past the vector.
    assign w_req8     = 8'(req);
    assign w_rel_norm = (r_state == S_BUSY) && (done || !w_req8[r_sel]);
    assign w_leave    = w_rel_norm || w_force;

`ifdef RR_SEL_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] r_hold;

    // Hold counter: zero while waiting, counts every BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_BUSY) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + 1'b1;
        end
    end

    // A normal release on the limit cycle wins, so timeout only fires alone.
    assign w_force = (r_state == S_BUSY) && !w_rel_norm &&
                     (r_hold == HOLD_W'(MAX_HOLD - 1));
`else
    assign w_force = 1'b0;
`endif

    // Round-robin scan from ptr upward with wrap; lowest offset wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = 3'd0;
        w_idx  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (w_req8[w_idx[2:0]]) begin
                w_any  = 1'b1;
                w_pick = w_idx[2:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE arbitrates, BUSY waits for release, GAP is one dead cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any)   w_next = S_BUSY;
            S_BUSY:  if (w_leave) w_next = S_GAP;
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs and priority pointer, all driven from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 3'd0;
            r_sel     <= 3'd0;
            r_gnt_vld <= 1'b0;
            r_gnt     <= 8'h00;
            r_timeout <= 1'b0;
        end else begin
            r_gnt_vld <= (w_next == S_BUSY);
            r_timeout <= w_force;
            if (r_state == S_IDLE && w_any) begin
                r_sel <= w_pick;
                r_gnt <= 8'd1 << w_pick;
            end else if (w_next != S_BUSY) begin
                r_gnt <= 8'h00;
            end
            if (r_state == S_BUSY && w_leave) begin
                r_ptr <= (r_sel == 3'(N_REQ - 1)) ? 3'd0 : r_sel + 3'd1;
            end
        end
    end

    assign gnt_vld = r_gnt_vld;
    assign gnt_sel = r_sel;
    assign gnt     = r_gnt;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed scoreboard bench for rr_sel_arbiter.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] req;
    logic       done;
    logic       gnt_vld;
    logic [2:0] gnt_sel;
    logic [7:0] gnt;
    logic       timeout;

    int         n_assert = 0;
    int         n_fail   = 0;
    bit         mon_on   = 1'b0;
    logic [2:0] exp_q[$];

    rr_sel_arbiter #(.N_REQ(6), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_vld(gnt_vld), .gnt_sel(gnt_sel), .gnt(gnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every cycle: grant vector matches select, select never 6 or 7.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("gnt_onehot", 32'(gnt), gnt_vld ? 32'(8'd1 << gnt_sel) : 32'd0);
                chk("sel_range", 32'(gnt_sel < 3'd6), 32'd1);
            end
        end
    end

    // Wait for the next grant (bounded), pop the expected owner, compare.
    task automatic wait_grant(input string tag, output int cycles);
        logic [2:0] e;
        cycles = 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (gnt_vld === 1'b1) break;
        end
        chk({tag, "_seen"}, 32'(gnt_vld), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sel"}, 32'(gnt_sel), 32'(e));
            chk({tag, "_gnt"}, 32'(gnt), 32'(8'd1 << e));
        end
    endtask

    // Pulse done for one cycle while optionally changing req.
    task automatic release_with(input logic [5:0] new_req);
        done = 1'b1;
        req  = new_req;
        @(negedge clk);
        done = 1'b0;
        chk("gap_vld", 32'(gnt_vld), 32'd0);
    endtask

    initial begin
        int cyc;
        int hi;
        bit saw_to;
        rst  = 1'b1;
        req  = 6'h3F;
        done = 1'b0;

        // Reset held with all requests high.
        repeat (2) begin
            @(negedge clk);
            chk("rst_vld", 32'(gnt_vld), 32'd0);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_sel", 32'(gnt_sel), 32'd0);
            chk("rst_to", 32'(timeout), 32'd0);
        end
        mon_on = 1'b1;
        rst = 1'b0;

        // Rotation 0..5,0 with two dead cycles between grants.
        exp_q.push_back(3'd0);
        wait_grant("first", cyc);
        chk("first_lat", 32'(cyc), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back(3'(i % 6));
            release_with(6'h3F);
            wait_grant("rot", cyc);
            chk("rot_spacing", 32'(cyc), 32'd2);
        end

        // Only 4 requesting: ptr=1 so grant 4; then wrap from ptr=5 to 0, then 2.
        exp_q.push_back(3'd4);
        release_with(6'h10);
        wait_grant("only4", cyc);
        exp_q.push_back(3'd0);
        release_with(6'b000101);
        wait_grant("wrap0", cyc);
        exp_q.push_back(3'd2);
        release_with(6'b000101);
        wait_grant("sparse2", cyc);

        // Grant 3, then withdraw it: next is lowest set bit above 3, wrapping to 0.
        exp_q.push_back(3'd3);
        release_with(6'b001001);
        wait_grant("get3", cyc);
        req = 6'b000011;
        @(negedge clk);
        chk("wd_vld", 32'(gnt_vld), 32'd0);
        exp_q.push_back(3'd0);
        wait_grant("wd_next", cyc);
        chk("wd_spacing", 32'(cyc), 32'd2);

        // done together with withdrawal: single release, then idle.
        release_with(6'h00);
        repeat (2) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("idle_done_vld", 32'(gnt_vld), 32'd0);
        @(negedge clk);
        chk("idle_done_vld2", 32'(gnt_vld), 32'd0);
        req = 6'h04;
        exp_q.push_back(3'd2);
        wait_grant("lat4", cyc);
        chk("lat4_cycles", 32'(cyc), 32'd1);

        // Single requester held with no done: timeout or persistent grant.
        exp_q.push_back(3'd1);
        release_with(6'h02);
        wait_grant("hold1", cyc);
        hi = 1;
        saw_to = 1'b0;
        while (hi < 120) begin
            @(negedge clk);
            if (timeout === 1'b1) saw_to = 1'b1;
            if (gnt_vld !== 1'b1) break;
            hi++;
        end
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
        chk("to_hold_len", 32'(hi), 32'd16);
        chk("to_pulse", 32'(timeout), 32'd1);
        exp_q.push_back(3'd1);
        wait_grant("to_regrant", cyc);
        chk("to_regrant_spacing", 32'(cyc), 32'd2);
        chk("to_pulse_end", 32'(timeout), 32'd0);
`else
        chk("hold_len", 32'(hi), 32'd120);
        chk("hold_vld", 32'(gnt_vld), 32'd1);
        chk("no_timeout", 32'(saw_to), 32'd0);
`endif

        // Reset mid-grant clears on the next edge with no timeout pulse.
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_vld", 32'(gnt_vld), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_sel", 32'(gnt_sel), 32'd0);
        chk("midrst_to", 32'(timeout), 32'd0);
        rst = 1'b0;
        req = 6'h00;
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
